// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM.
// Drives datapath strobes, counts retired instructions, flags HALT/FAULT.
module instr_sequencer #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic [1:0]       category,
    input  logic             alu_zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_load,
    output logic             alu_en,
    output logic             mem_re,
    output logic             mem_we,
    output logic             reg_we,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    // FSM state encoding (also the externally visible state code)
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    // Instruction categories from control_unit
    localparam logic [1:0] C_ALU  = 2'b00;
    localparam logic [1:0] C_MEM  = 2'b01;
    localparam logic [1:0] C_CTRL = 2'b10;
    localparam logic [1:0] C_SYS  = 2'b11;

    // Opcodes that change sequencing
    localparam logic [3:0] OP_LOAD = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd6;
    localparam logic [3:0] OP_JAL  = 4'd7;

    // PC source select
    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    // Wait counter just wide enough for the timeout limit
    localparam int WAIT_W =
        (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam bit TO_EN = (MEM_TIMEOUT > 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        TO_EN ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

    logic [2:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_clr;
    logic              wait_inc;
    logic              ret_halt;
    logic              is_load;
    logic              wait_hit;

    assign is_load  = (opcode == OP_LOAD);
    assign wait_hit = TO_EN && (wait_cnt == WAIT_LAST);

    // Next-state and strobe decode from the registered state
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        alu_en    = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        pc_en     = 1'b0;
        pc_sel    = PC_INC;
        halted    = 1'b0;
        fault     = 1'b0;
        wait_clr  = 1'b0;
        wait_inc  = 1'b0;
        ret_halt  = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load   = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (category != C_SYS) begin
                    state_nxt = S_EXEC;
                end else if (opcode == OP_HALT) begin
                    ret_halt  = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    pc_en     = 1'b1;
                    pc_sel    = PC_INC;
                    state_nxt = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_en = 1'b1;
                case (category)
                    C_ALU: begin
                        state_nxt = S_WB;
                    end
                    C_MEM: begin
                        wait_clr  = 1'b1;
                        state_nxt = S_MEM;
                    end
                    C_CTRL: begin
                        pc_en     = 1'b1;
                        state_nxt = S_FETCH;
                        if (opcode == OP_BEQ) begin
                            pc_sel = alu_zero ? PC_BR : PC_INC;
                        end else if (opcode == OP_JAL) begin
                            reg_we = 1'b1;
                            pc_sel = PC_JMP;
                        end else begin
                            pc_sel = PC_INC;
                        end
                    end
                    default: begin
                        pc_en     = 1'b1;
                        pc_sel    = PC_INC;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                mem_re = is_load;
                mem_we = !is_load;
                if (dmem_ready) begin
                    if (is_load) begin
                        state_nxt = S_WB;
                    end else begin
                        pc_en     = 1'b1;
                        pc_sel    = PC_INC;
                        state_nxt = S_FETCH;
                    end
                end else if (wait_hit) begin
                    state_nxt = S_FAULT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_WB: begin
                reg_we    = 1'b1;
                pc_en     = 1'b1;
                pc_sel    = PC_INC;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_FAULT: begin
                halted = 1'b1;
                fault  = 1'b1;
            end
            default: begin
                halted    = 1'b1;
                fault     = 1'b1;
                state_nxt = S_FAULT;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Data-memory wait counter, cleared on MEM entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (wait_clr) begin
            wait_cnt <= '0;
        end else if (wait_inc && TO_EN) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (pc_en || ret_halt) begin
            retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: plan-driven stimulus with a per-cycle scoreboard.
// Expected cycle sequences are built from the instruction class rules.
module tb_instr_sequencer;

    localparam int TO = 15;

    localparam logic [2:0] F   = 3'd0;
    localparam logic [2:0] D   = 3'd1;
    localparam logic [2:0] E   = 3'd2;
    localparam logic [2:0] M   = 3'd3;
    localparam logic [2:0] W   = 3'd4;
    localparam logic [2:0] H   = 3'd5;
    localparam logic [2:0] FLT = 3'd6;

    // strobe bits {ir_load, alu_en, mem_re, mem_we, reg_we, pc_en}
    localparam logic [5:0] S_IR  = 6'b100000;
    localparam logic [5:0] S_ALU = 6'b010000;
    localparam logic [5:0] S_RE  = 6'b001000;
    localparam logic [5:0] S_WE  = 6'b000100;
    localparam logic [5:0] S_RW  = 6'b000010;
    localparam logic [5:0] S_PC  = 6'b000001;
    localparam logic [5:0] S_NO  = 6'b000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  opcode = 4'd8;
    logic [1:0]  category = 2'b11;
    logic        alu_zero = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, ir_load, alu_en, mem_re, mem_we;
    logic        reg_we, pc_en, halted, fault;
    logic [1:0]  pc_sel;
    logic [2:0]  state;
    logic [15:0] retired;

    logic [29:0] exp_q[$];
    string       name_q[$];
    logic [15:0] ret_model = '0;
    int          checks = 0;
    int          failures = 0;

    instr_sequencer #(.CNT_W(16), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .category(category),
        .alu_zero(alu_zero), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .imem_req(imem_req),
        .ir_load(ir_load), .alu_en(alu_en), .mem_re(mem_re),
        .mem_we(mem_we), .reg_we(reg_we), .pc_en(pc_en),
        .pc_sel(pc_sel), .state(state), .halted(halted),
        .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Monitor: one expected record per cycle, compared mid-cycle
    always @(negedge clk) begin
        logic [29:0] act;
        logic [29:0] e;
        string       nm;
        act = {state, imem_req, ir_load, alu_en, mem_re, mem_we,
               reg_we, pc_en, pc_sel, halted, fault, retired};
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s t=%0t got st=%0d strb=%b sel=%0d hf=%b ret=%0d want st=%0d strb=%b sel=%0d hf=%b ret=%0d",
                         nm, $time, act[29:27], act[26:20], act[19:18],
                         act[17:16], act[15:0], e[29:27], e[26:20],
                         e[19:18], e[17:16], e[15:0]);
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [1:0] cat_of(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd2: return 2'b00;
            4'd3, 4'd4:       return 2'b01;
            4'd5, 4'd7:       return 2'b10;
            default:          return 2'b11;
        endcase
    endfunction

    // Drive one cycle of inputs and queue the expected outputs
    task automatic step(input string nm, input logic [2:0] st,
                        input logic [5:0] strb, input logic [1:0] sel,
                        input logic imr, input logic dmr, input logic az,
                        input bit inc);
        logic [29:0] e;
        imem_ready = imr;
        dmem_ready = dmr;
        alu_zero   = az;
        e = {st, 1'(st == F), strb, sel,
             1'(st == H || st == FLT), 1'(st == FLT), ret_model};
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        if (strb[0] || inc) ret_model = ret_model + 16'd1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = rb();
        #1;
        ret_model = '0;
        exp_q.push_back({F, 1'b1, S_NO, 2'b00, 2'b00, 16'd0});
        name_q.push_back("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Expected cycle sequence of one instruction from its class rules
    task automatic run_instr(input logic [3:0] op, input int wi,
                             input int wd, input logic az,
                             output bit stop);
        logic [1:0] cat;
        logic [5:0] m;
        int         nrdy;
        cat      = cat_of(op);
        opcode   = op;
        category = cat;
        stop     = 1'b0;
        for (int i = 0; i < wi; i++)
            step("fetch_wait", F, S_NO, 2'b00, 1'b0, rb(), rb(), 1'b0);
        step("fetch", F, S_IR, 2'b00, 1'b1, rb(), rb(), 1'b0);
        if (cat == 2'b11) begin
            if (op == 4'd6) begin
                step("decode_halt", D, S_NO, 2'b00, rb(), rb(), rb(), 1'b1);
                for (int i = 0; i < 4; i++)
                    step("halt_sticky", H, S_NO, 2'b00, rb(), rb(), rb(), 1'b0);
                stop = 1'b1;
            end else begin
                step("decode_sys", D, S_PC, 2'b00, rb(), rb(), rb(), 1'b0);
            end
            return;
        end
        step("decode", D, S_NO, 2'b00, rb(), rb(), rb(), 1'b0);
        case (cat)
            2'b00: begin
                step("exec_alu", E, S_ALU, 2'b00, rb(), rb(), rb(), 1'b0);
                step("wb_alu", W, S_RW | S_PC, 2'b00, rb(), rb(), rb(), 1'b0);
            end
            2'b01: begin
                step("exec_mem", E, S_ALU, 2'b00, rb(), rb(), rb(), 1'b0);
                m    = (op == 4'd3) ? S_RE : S_WE;
                nrdy = (wd >= TO) ? TO : wd;
                for (int i = 0; i < nrdy; i++)
                    step("mem_wait", M, m, 2'b00, rb(), 1'b0, rb(), 1'b0);
                if (wd >= TO) begin
                    for (int i = 0; i < 4; i++)
                        step("fault_sticky", FLT, S_NO, 2'b00, rb(), rb(), rb(), 1'b0);
                    stop = 1'b1;
                    return;
                end
                if (op == 4'd3) begin
                    step("mem_load", M, S_RE, 2'b00, rb(), 1'b1, rb(), 1'b0);
                    step("wb_load", W, S_RW | S_PC, 2'b00, rb(), rb(), rb(), 1'b0);
                end else begin
                    step("mem_store", M, S_WE | S_PC, 2'b00, rb(), 1'b1, rb(), 1'b0);
                end
            end
            default: begin
                if (op == 4'd5)
                    step("exec_beq", E, S_ALU | S_PC, az ? 2'b01 : 2'b00,
                         rb(), rb(), az, 1'b0);
                else
                    step("exec_jal", E, S_ALU | S_RW | S_PC, 2'b10,
                         rb(), rb(), rb(), 1'b0);
            end
        endcase
    endtask

    initial begin
        bit          stop;
        logic [3:0]  ops [10];
        logic [3:0]  op;
        int          wd;
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd15, 4'd6};
        @(posedge clk);
        #1;
        do_reset();
        // directed: ADD, LOAD with waits, BEQ both ways, JAL, NOP, unknown
        run_instr(4'd0, 0, 0, 1'b0, stop);
        run_instr(4'd3, 0, 3, 1'b0, stop);
        run_instr(4'd5, 0, 0, 1'b1, stop);
        run_instr(4'd5, 0, 0, 1'b0, stop);
        run_instr(4'd7, 0, 0, 1'b0, stop);
        run_instr(4'd8, 0, 0, 1'b0, stop);
        run_instr(4'd15, 0, 0, 1'b0, stop);
        run_instr(4'd6, 0, 0, 1'b0, stop);
        do_reset();
        // STORE timeout, then ready on the limit cycle
        run_instr(4'd4, 0, TO, 1'b0, stop);
        do_reset();
        run_instr(4'd4, 1, TO - 1, 1'b0, stop);
        run_instr(4'd3, 0, TO - 1, 1'b0, stop);
        // reset mid-MEM of a LOAD
        opcode   = 4'd3;
        category = 2'b01;
        step("fetch", F, S_IR, 2'b00, 1'b1, rb(), rb(), 1'b0);
        step("decode", D, S_NO, 2'b00, rb(), rb(), rb(), 1'b0);
        step("exec_mem", E, S_ALU, 2'b00, rb(), rb(), rb(), 1'b0);
        step("mem_wait", M, S_RE, 2'b00, rb(), 1'b0, rb(), 1'b0);
        do_reset();
        run_instr(4'd0, 0, 0, 1'b0, stop);
        // randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            op = ops[$urandom_range(0, ($urandom_range(0, 19) == 0) ? 9 : 8)];
            wd = $urandom_range(0, 3);
            if ($urandom_range(0, 24) == 0)
                wd = ($urandom_range(0, 1) == 1) ? TO - 1 : TO + 3;
            run_instr(op, $urandom_range(0, 2), wd, rb(), stop);
            if (stop) do_reset();
        end
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d left want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
